// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: opcodes and fetch FSM states.
package mips_pkg;

    localparam logic [5:0] OP_J   = 6'b000010;
    localparam logic [5:0] OP_JAL = 6'b000011;
    localparam logic [5:0] OP_BEQ = 6'b000100;
    localparam logic [5:0] OP_BNE = 6'b000101;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        HOLD
    } fetch_state_t;

endpackage

// File: rtl/ifetch32_if.sv
// Instruction memory req/ack bus between fetch unit and memory.
interface ifetch32_if;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );

endinterface

// File: rtl/ifetch32_npc_calc.sv
// Next-PC selection: JR, then J/JAL, then taken branch, then sequential.
module npc_calc (
    input  logic [31:0] opcplus4,
    input  logic [25:0] jump_index,
    input  logic [29:0] rs_word,
    input  logic [29:0] imm_word,
    input  logic        Branch,
    input  logic        nBranch,
    input  logic        Jmp,
    input  logic        Jal,
    input  logic        Jrn,
    input  logic        Zero,
    output logic [31:0] next_pc,
    output logic [31:0] next_plus4
);

    logic        taken;
    logic [31:0] br_target;

    assign taken     = (Branch & Zero) | (nBranch & ~Zero);
    assign br_target = opcplus4 + {imm_word, 2'b00};

    always_comb begin
        next_pc = opcplus4;
        priority case (1'b1)
            Jrn:         next_pc = {rs_word, 2'b00};
            Jmp | Jal:   next_pc = {opcplus4[31:28], jump_index, 2'b00};
            taken:       next_pc = br_target;
            default:     next_pc = opcplus4;
        endcase
    end

    assign next_plus4 = next_pc + 32'd4;

endmodule

// File: rtl/ifetch32.sv
// Instruction fetch unit: PC, req/ack fetch FSM and instruction register.
module ifetch32 #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    ifetch32_if.master  imem,
    output logic [31:0] Instruction,
    output logic        inst_valid,
    input  logic        advance,
    input  logic        Branch,
    input  logic        nBranch,
    input  logic        Jmp,
    input  logic        Jal,
    input  logic        Jrn,
    input  logic        Zero,
    input  logic [31:0] Sign_extend,
    input  logic [31:0] read_data_1,
    output logic [31:0] PC,
    output logic [31:0] opcplus4
);

    import mips_pkg::*;

    fetch_state_t state, state_d;
    logic [31:0]  next_pc;
    logic [31:0]  next_plus4;
    logic         unused_bits;

    assign unused_bits = ^{read_data_1[1:0], Sign_extend[31:30],
                           Instruction[31:26]};

    npc_calc u_npc (
        .opcplus4   (opcplus4),
        .jump_index (Instruction[25:0]),
        .rs_word    (read_data_1[31:2]),
        .imm_word   (Sign_extend[29:0]),
        .Branch     (Branch),
        .nBranch    (nBranch),
        .Jmp        (Jmp),
        .Jal        (Jal),
        .Jrn        (Jrn),
        .Zero       (Zero),
        .next_pc    (next_pc),
        .next_plus4 (next_plus4)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_d;
    end

    // IDLE always lasts one cycle so a stale ack from before reset drains.
    always_comb begin
        state_d       = state;
        imem.imem_req = 1'b0;
        inst_valid    = 1'b0;
        unique case (state)
            IDLE: state_d = FETCH;
            FETCH: begin
                imem.imem_req = 1'b1;
                if (imem.imem_ack) state_d = HOLD;
            end
            HOLD: begin
                inst_valid = 1'b1;
                if (advance) state_d = FETCH;
            end
            default: state_d = IDLE;
        endcase
    end

    assign imem.imem_addr = PC;

    always_ff @(posedge clk) begin
        if (rst) begin
            PC          <= RESET_PC;
            opcplus4    <= RESET_PC + 32'd4;
            Instruction <= '0;
        end else begin
            if (state == FETCH && imem.imem_ack)
                Instruction <= imem.imem_rdata;
            if (state == HOLD && advance) begin
                PC       <= next_pc;
                opcplus4 <= next_plus4;
            end
        end
    end

endmodule

// File: doc/ifetch32.md
# ifetch32

Instruction fetch unit for the 32-bit MIPS core: it is the producer of the `Instruction` and `opcplus4` signals that the instruction decoder consumes. It holds the PC and fetches words from instruction memory over a req/ack handshake. It presents each instruction to the core until the core retires it, then computes the next PC from the sequential, branch, J/JAL and JR paths.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset; must be word-aligned.
- `clk`  in  1  core clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `imem_req`  out  1  fetch request to instruction memory.
- `imem_addr`  out  32  byte address of the word being fetched; bits [1:0] always 0.
- `imem_ack`  in  1  memory has valid data on `imem_rdata` this cycle.
- `imem_rdata`  in  32  fetched instruction word.
- `Instruction`  out  32  registered instruction currently presented to the decoder.
- `inst_valid`  out  1  `Instruction` is valid and awaiting retirement.
- `advance`  in  1  core retires the current instruction; control inputs are valid.
- `Branch`, `nBranch`, `Jmp`, `Jal`, `Jrn`  in  1 each  control-unit flags for the current instruction.
- `Zero`  in  1  ALU zero flag for the current instruction.
- `Sign_extend`  in  32  sign-extended immediate from the decoder.
- `read_data_1`  in  32  rs value from the decoder; used as the JR target.
- `PC`  out  32  address of the current instruction.
- `opcplus4`  out  32  PC + 4 of the current instruction; the JAL link value.

## Operation
- The FSM has three states: IDLE, FETCH and HOLD. Reset state is IDLE.
- IDLE: `imem_req` = 0. Unconditionally moves to FETCH on the next cycle, which drains any ack left over from a request made before reset.
- FETCH: `imem_req` = 1 and `imem_addr` = PC. Both are held stable until ack. On `imem_ack`, the block captures `imem_rdata` into `Instruction` and moves to HOLD.
- HOLD: `inst_valid` = 1 and `imem_req` = 0. On `advance`, PC and `opcplus4` are updated and the state returns to FETCH.
- Next-PC priority, highest first:
  - `Jrn`: `{read_data_1[31:2], 2'b00}`.
  - `Jmp` or `Jal`: `{opcplus4[31:28], Instruction[25:0], 2'b00}`.
  - Branch taken (`Branch`&`Zero` or `nBranch`&~`Zero`): `opcplus4 + {Sign_extend[29:0], 2'b00}`.
  - Otherwise: `opcplus4`.
- All additions are 32-bit modulo; carry is discarded and addresses wrap.
- On `advance`: PC <= next PC, and `opcplus4` <= next PC + 4.
- `opcplus4` stays stable for the whole HOLD period, so the decoder links the correct return address on the retiring edge.
- `imem_ack` is ignored outside FETCH. `advance` and all control inputs are ignored outside HOLD.
- Reset values: PC = `RESET_PC`; `opcplus4` = `RESET_PC` + 4; `Instruction` = 0; `inst_valid` = 0; `imem_req` = 0; `imem_addr` = `RESET_PC`.
- Reset in any state, including mid-fetch or HOLD, overrides all other inputs on that edge.

## Timing
- Same-cycle `imem_ack` (the cycle `imem_req` rises) is legal. `inst_valid` then rises on the following cycle.
- Minimum throughput is 2 cycles per instruction: 1 FETCH + 1 HOLD with `advance` high.
- Fetch latency equals memory latency in cycles, plus 1 cycle of registration.
- The new `imem_addr` appears on the cycle after `advance`, already qualified by `imem_req`.
- First `imem_req` appears 2 cycles after `rst` deasserts: the first cycle is IDLE.

## Structure
- Shared package `mips_pkg`:
  - Opcode constants: J = 6'b000010, JAL = 6'b000011, BEQ = 6'b000100, BNE = 6'b000101.
  - FSM state enum: IDLE, FETCH, HOLD.
- One combinational sub-module, `npc_calc`, implements the next-PC priority mux and adders.
- `ifetch32` keeps the FSM and the PC, `opcplus4` and `Instruction` registers.

## Test plan
- **Reset:** `rst` high for 2 cycles.
  - During reset: PC = 0, `opcplus4` = 4, `inst_valid` = 0, `imem_req` = 0.
  - `imem_req` rises on the 2nd cycle after release, with `imem_addr` = 0.
- **Sequential fetch:** ack 32'h0043_3820 (add $7,$2,$3) after 2 cycles.
  - `Instruction` = 32'h0043_3820 and `inst_valid` = 1.
  - `advance` with all controls low gives PC = 4, `opcplus4` = 8, `imem_addr` = 4.
- **Branch:** at PC = 0x8 with `Branch` = 1, `Sign_extend` = 32'hFFFF_FFFE.
  - `Zero` = 1 gives next PC 0x4.
  - `Zero` = 0 gives 0xC.
  - `nBranch` = 1 with `Zero` = 0 gives 0x4.
- **JAL:** at PC = 0x14 with `Instruction` = 32'h0C00_0010 and `Jal` = 1.
  - `opcplus4` = 0x18 throughout HOLD.
  - After `advance`: PC = 0x40, `opcplus4` = 0x44.
- **JR priority and alignment:** `Jrn` = `Branch` = `Zero` = 1 with `read_data_1` = 32'h0000_0103 gives PC = 0x100.
- **Wrap and mid-fetch reset:**
  - PC = 32'hFFFF_FFFC with sequential `advance` gives PC = 0, `opcplus4` = 4.
  - Assert `rst` while in FETCH, then drive `imem_ack` during reset and the following IDLE cycle. The ack is ignored, PC = `RESET_PC`, and `inst_valid` stays 0.
